// File: rtl/sync_mem_init_pkg.sv
// Shared types and sizing helpers for the sync_mem initiator.
//   state_e   : control FSM states (IDLE, DRAIN, FILL, DONE)
//   mem_words : number of words in a memory with a given address width
//   credit_w  : width of a counter that must hold 0..rsp_depth inclusive
package sync_mem_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int mem_words(input int depth);
    return 1 << depth;
  endfunction

  function automatic int credit_w(input int rsp_depth);
    return $clog2(rsp_depth + 1);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// First-word-fall-through response FIFO.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wdata  : write one entry (ignored when full)
//   pop          : discard the head entry (ignored when empty)
//   rdata        : head entry, valid whenever empty is low
//   full, empty  : occupancy flags
module rsp_fifo #(
  parameter int WIDTH     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(RSP_DEPTH);

  logic [WIDTH-1:0] store [RSP_DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = store[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) store[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sync_mem_initiator.sv
// Initiator for one port of sync_mem. Converts a valid/ready request stream
// into registered memory port cycles, returns read data in order through a
// buffered valid/ready response stream, and provides a fill sequencer that
// writes one value to every address.
// Ports:
//   clock, reset                        : rising-edge clock, async active-high reset
//   reqValid/reqReady/reqWrite          : request handshake and direction
//   reqAddress/reqWriteData             : request address and write data
//   rspValid/rspReady/rspData           : read response stream (request order)
//   fillStart/fillValue                 : start a fill with the given value
//   fillBusy/fillDone                   : fill in progress / one-cycle completion pulse
//   memWriteEnable/memWriteData/memAddress : registered drive to sync_mem
//   memReadData                         : sync_mem read data (one cycle after address)
module sync_mem_initiator
  import sync_mem_init_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqWrite,
  input  logic [DEPTH-1:0] reqAddress,
  input  logic [WIDTH-1:0] reqWriteData,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
  input  logic             fillStart,
  input  logic [WIDTH-1:0] fillValue,
  output logic             fillBusy,
  output logic             fillDone,
  output logic             memWriteEnable,
  output logic [WIDTH-1:0] memWriteData,
  output logic [DEPTH-1:0] memAddress,
  input  logic [WIDTH-1:0] memReadData
);

  localparam int            MEM_WORDS = mem_words(DEPTH);
  localparam int            CW        = credit_w(RSP_DEPTH);
  localparam logic [CW-1:0] CRED_MAX  = CW'(RSP_DEPTH);
  localparam logic [DEPTH:0] FILL_END = (DEPTH+1)'(MEM_WORDS);

  state_e           state;
  state_e           state_nxt;
  logic [CW-1:0]    credits;
  logic [DEPTH:0]   fill_cnt;
  logic [DEPTH:0]   fill_cnt_nxt;
  logic [WIDTH-1:0] fill_val;
  logic             vld_p0;
  logic             vld_p1;
  logic             rd_acc;
  logic             wr_acc;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             we_nxt;
  logic [DEPTH-1:0] addr_nxt;
  logic [WIDTH-1:0] wd_nxt;

  // Reset gating keeps every output low while reset is held.
  assign reqReady = !reset && (state == IDLE) && !fillStart &&
                    (reqWrite || (credits != '0));
  assign rd_acc   = reqValid && reqReady && !reqWrite;
  assign wr_acc   = reqValid && reqReady && reqWrite;
  assign rspValid = !fifo_empty;
  assign rspData  = rspValid ? fifo_rdata : '0;
  assign pop      = rspValid && rspReady;
  assign fillBusy = (state != IDLE);
  assign fillDone = (state == DONE);

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    we_nxt       = 1'b0;
    addr_nxt     = memAddress;
    wd_nxt       = memWriteData;
    case (state)
      IDLE: begin
        if (fillStart) begin
          state_nxt    = (vld_p0 || vld_p1) ? DRAIN : FILL;
          fill_cnt_nxt = '0;
        end else if (wr_acc) begin
          we_nxt   = 1'b1;
          addr_nxt = reqAddress;
          wd_nxt   = reqWriteData;
        end else if (rd_acc) begin
          addr_nxt = reqAddress;
        end
      end
      DRAIN: begin
        if (!vld_p0 && !vld_p1) state_nxt = FILL;
      end
      FILL: begin
        // The counter runs one past the last address, so the cycle that sees
        // the extra bit set issues nothing and hands over to DONE.
        if (fill_cnt == FILL_END) begin
          state_nxt = DONE;
        end else begin
          we_nxt       = 1'b1;
          addr_nxt     = fill_cnt[DEPTH-1:0];
          wd_nxt       = fill_val;
          fill_cnt_nxt = fill_cnt + (DEPTH+1)'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fill_cnt       <= '0;
      credits        <= CRED_MAX;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memWriteData   <= '0;
    end else begin
      state          <= state_nxt;
      fill_cnt       <= fill_cnt_nxt;
      memWriteEnable <= we_nxt;
      memAddress     <= addr_nxt;
      memWriteData   <= wd_nxt;
      // p0: address presented to sync_mem
      vld_p0         <= rd_acc;
      // p1: sync_mem read data valid, pushed into the FIFO at the next edge
      vld_p1         <= vld_p0;
      case ({rd_acc, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && fillStart) fill_val <= fillValue;
  end

  rsp_fifo #(
    .WIDTH     (WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (vld_p1),
    .wdata (memReadData),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Credits bound the reads in flight plus buffered, so the FIFO never overflows.
  assert property (@(posedge clock) disable iff (reset) !(vld_p1 && fifo_full));

endmodule
